// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: moves one operation word from FIFO_IN through the ALU
// and pushes a tagged result word into FIFO_OUT.
// Bit FIFO_OUT_WIDTH-1 of each pushed word flags an illegal op or a timeout.
module alu_op_sequencer #(
  parameter int DATA_WIDTH     = 12,
  parameter int OPERATION_SIZE = 2,
  parameter int FIFO_OUT_WIDTH = 25,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  seq_en,
  input  logic                                  err_clr,
  input  logic                                  empty_in,
  input  logic [OPERATION_SIZE+2*DATA_WIDTH-1:0] fifo_in_rdata,
  output logic                                  r_en_in,
  output logic                                  alu_start,
  output logic [OPERATION_SIZE-1:0]             alu_op,
  output logic [DATA_WIDTH-1:0]                 alu_a,
  output logic [DATA_WIDTH-1:0]                 alu_b,
  input  logic                                  alu_done,
  input  logic [FIFO_OUT_WIDTH-2:0]             alu_result,
  input  logic                                  full_out,
  output logic                                  w_en_out,
  output logic [FIFO_OUT_WIDTH-1:0]             fifo_out_wdata,
  output logic                                  busy,
  output logic [COUNT_WIDTH-1:0]                op_count,
  output logic                                  timeout_err
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FIFO_OUT_WIDTH-1:0] ILLEGAL_WORD = {1'b1, {(FIFO_OUT_WIDTH-1){1'b0}}};
  localparam logic [FIFO_OUT_WIDTH-1:0] TIMEOUT_WORD = {FIFO_OUT_WIDTH{1'b1}};
  localparam logic [OPERATION_SIZE-1:0] OP_A = OPERATION_SIZE'(1);
  localparam logic [OPERATION_SIZE-1:0] OP_B = OPERATION_SIZE'(2);

  typedef enum logic [2:0] {IDLE, POP, CAPT, EXEC, WAIT, PUSH} state_t;

  state_t                      state_q, state_d;
  logic [OPERATION_SIZE-1:0]   alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0]       alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]       alu_b_q, alu_b_d;
  logic [FIFO_OUT_WIDTH-1:0]   wdata_q, wdata_d;
  logic [COUNT_WIDTH-1:0]      op_count_q, op_count_d;
  logic                        timeout_err_q, timeout_err_d;
  logic [WAIT_W-1:0]           wait_cnt_q, wait_cnt_d;

  logic [OPERATION_SIZE-1:0]   in_op;
  logic [DATA_WIDTH-1:0]       in_data0;
  logic [DATA_WIDTH-1:0]       in_data1;

  assign in_op    = fifo_in_rdata[2*DATA_WIDTH +: OPERATION_SIZE];
  assign in_data1 = fifo_in_rdata[DATA_WIDTH +: DATA_WIDTH];
  assign in_data0 = fifo_in_rdata[0 +: DATA_WIDTH];

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      wdata_q       <= '0;
      op_count_q    <= '0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      wdata_q       <= wdata_d;
      op_count_q    <= op_count_d;
      timeout_err_q <= timeout_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // Next-state and strobe decode; a timeout set overrides a same-cycle err_clr.
  always_comb begin
    state_d       = state_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    wdata_d       = wdata_q;
    op_count_d    = op_count_q;
    timeout_err_d = err_clr ? 1'b0 : timeout_err_q;
    wait_cnt_d    = wait_cnt_q;
    r_en_in       = 1'b0;
    alu_start     = 1'b0;
    w_en_out      = 1'b0;
    busy          = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (seq_en && !empty_in) state_d = POP;
      end
      POP: begin
        r_en_in = 1'b1;
        state_d = CAPT;
      end
      CAPT: begin
        alu_op_d = in_op;
        alu_a_d  = in_data0;
        alu_b_d  = in_data1;
        if (in_op == OP_A || in_op == OP_B) begin
          state_d = EXEC;
        end else begin
          wdata_d = ILLEGAL_WORD;
          state_d = PUSH;
        end
      end
      EXEC: begin
        alu_start  = 1'b1;
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (alu_done) begin
          wdata_d = {1'b0, alu_result};
          state_d = PUSH;
        end else if (wait_cnt_q == WAIT_LAST) begin
          wdata_d       = TIMEOUT_WORD;
          timeout_err_d = 1'b1;
          state_d       = PUSH;
        end
      end
      PUSH: begin
        if (!full_out) begin
          w_en_out   = 1'b1;
          op_count_d = op_count_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_op         = alu_op_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign fifo_out_wdata = wdata_q;
  assign op_count       = op_count_q;
  assign timeout_err    = timeout_err_q;

endmodule
